// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin shared ALU with valid/ready request and response ports (optional ALU_ARB_STATS_EN op counter)

package defs;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  typedef struct packed {
    logic sign;
    logic zero;
    logic overflow;
    logic carryOut;
  } t_flag;
endpackage

// Combinational ALU; carryOut on SUB is the borrow out of x - y.
module alu #(
  parameter int N = 32
) (
  input  logic [N-1:0] iX,
  input  logic [N-1:0] iY,
  input  logic [3:0]   iOp,
  output logic [N-1:0] oF,
  output defs::t_flag  oFlag
);
  logic [N:0] sum_w;
  logic [N:0] diff_w;

  // Decode the opcode; anything unrecognised falls back to ADD.
  always_comb begin
    sum_w          = {1'b0, iX} + {1'b0, iY};
    diff_w         = {1'b0, iX} - {1'b0, iY};
    oF             = sum_w[N-1:0];
    oFlag          = '0;
    oFlag.carryOut = sum_w[N];
    oFlag.overflow = (iX[N-1] == iY[N-1]) && (sum_w[N-1] != iX[N-1]);
    case (iOp)
      defs::OP_SUB: begin
        oF             = diff_w[N-1:0];
        oFlag.carryOut = diff_w[N];
        oFlag.overflow = (iX[N-1] != iY[N-1]) && (diff_w[N-1] != iX[N-1]);
      end
      defs::OP_AND: begin
        oF             = iX & iY;
        oFlag.carryOut = 1'b0;
        oFlag.overflow = 1'b0;
      end
      defs::OP_OR: begin
        oF             = iX | iY;
        oFlag.carryOut = 1'b0;
        oFlag.overflow = 1'b0;
      end
      defs::OP_XOR: begin
        oF             = iX ^ iY;
        oFlag.carryOut = 1'b0;
        oFlag.overflow = 1'b0;
      end
      default: ;
    endcase
    oFlag.sign = oF[N-1];
    oFlag.zero = (oF == '0);
  end
endmodule

module alu_share_arb #(
  parameter int N    = 32,
  parameter int NREQ = 2
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic [NREQ-1:0]   iReqValid,
  output logic [NREQ-1:0]   oReqReady,
  input  logic [NREQ*N-1:0] iReqX,
  input  logic [NREQ*N-1:0] iReqY,
  input  logic [NREQ*4-1:0] iReqOp,
  output logic [NREQ-1:0]   oRspValid,
  input  logic [NREQ-1:0]   iRspReady,
  output logic [N-1:0]      oRspF,
  output defs::t_flag       oRspFlag
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]       oOpCnt
`endif
);
  localparam int PW = $clog2(NREQ);
  localparam int SW = PW + 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} t_state;

  t_state         state_q, state_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [N-1:0]   x_q, x_d;
  logic [N-1:0]   y_q, y_d;
  logic [3:0]     op_q, op_d;
  logic [N-1:0]   rsp_f_q, rsp_f_d;
  defs::t_flag    rsp_flag_q, rsp_flag_d;

  logic [N-1:0]   req_x  [NREQ];
  logic [N-1:0]   req_y  [NREQ];
  logic [3:0]     req_op [NREQ];
  logic [SW-1:0]  scan;
  logic [PW-1:0]  winner;
  logic           found;
  logic [N-1:0]   alu_f;
  defs::t_flag    alu_flag;
  logic           rsp_hs;

  // Split the packed request buses into per-requester slices.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      req_x[k]  = iReqX[k*N +: N];
      req_y[k]  = iReqY[k*N +: N];
      req_op[k] = iReqOp[k*4 +: 4];
    end
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan = {1'b0, rr_ptr_q} + SW'(i);
      if (scan >= SW'(NREQ)) scan = scan - SW'(NREQ);
      if (!found && iReqValid[scan[PW-1:0]]) begin
        found  = 1'b1;
        winner = scan[PW-1:0];
      end
    end
  end

  alu #(.N(N)) u_alu (
    .iX    (x_q),
    .iY    (y_q),
    .iOp   (op_q),
    .oF    (alu_f),
    .oFlag (alu_flag)
  );

  assign rsp_hs = (state_q == RESP) && iRspReady[owner_q];

  // Next-state, operand capture and handshake outputs.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    x_d        = x_q;
    y_d        = y_q;
    op_d       = op_q;
    rsp_f_d    = rsp_f_q;
    rsp_flag_d = rsp_flag_q;
    oReqReady  = '0;
    oRspValid  = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          oReqReady[winner] = 1'b1;
          x_d     = req_x[winner];
          y_d     = req_y[winner];
          op_d    = req_op[winner];
          owner_d = winner;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_f_d    = alu_f;
        rsp_flag_d = alu_flag;
        state_d    = RESP;
      end
      RESP: begin
        oRspValid[owner_q] = 1'b1;
        if (rsp_hs) begin
          rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A grant while reset is held would be discarded anyway; keep ready low.
    if (!iRst_n) oReqReady = '0;
  end

  // State and datapath registers.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      op_q       <= '0;
      rsp_f_q    <= '0;
      rsp_flag_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      x_q        <= x_d;
      y_q        <= y_d;
      op_q       <= op_d;
      rsp_f_q    <= rsp_f_d;
      rsp_flag_q <= rsp_flag_d;
    end
  end

  assign oRspF    = rsp_f_q;
  assign oRspFlag = rsp_flag_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] op_cnt_q, op_cnt_d;

  // Count completed responses, sticking at all-ones.
  always_comb begin
    op_cnt_d = op_cnt_q;
    if (rsp_hs && (op_cnt_q != 16'hFFFF)) op_cnt_d = op_cnt_q + 16'd1;
  end

  // Completed-operation counter register.
  always_ff @(posedge iClk) begin
    if (!iRst_n) op_cnt_q <= '0;
    else         op_cnt_q <= op_cnt_d;
  end

  assign oOpCnt = op_cnt_q;
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed self-checking bench for alu_share_arb (N=32, NREQ=2)

module tb_alu_share_arb;
  localparam int N    = 32;
  localparam int NREQ = 2;

  logic              iClk;
  logic              iRst_n;
  logic [NREQ-1:0]   iReqValid;
  logic [NREQ-1:0]   oReqReady;
  logic [NREQ*N-1:0] iReqX;
  logic [NREQ*N-1:0] iReqY;
  logic [NREQ*4-1:0] iReqOp;
  logic [NREQ-1:0]   oRspValid;
  logic [NREQ-1:0]   iRspReady;
  logic [N-1:0]      oRspF;
  defs::t_flag       oRspFlag;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]       oOpCnt;
`endif

  int checks = 0;
  int errors = 0;

  alu_share_arb #(.N(N), .NREQ(NREQ)) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iReqValid (iReqValid),
    .oReqReady (oReqReady),
    .iReqX     (iReqX),
    .iReqY     (iReqY),
    .iReqOp    (iReqOp),
    .oRspValid (oRspValid),
    .iRspReady (iRspReady),
    .oRspF     (oRspF),
    .oRspFlag  (oRspFlag)
`ifdef ALU_ARB_STATS_EN
    ,
    .oOpCnt    (oOpCnt)
`endif
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    iReqX[k*N +: N] = x;
    iReqY[k*N +: N] = y;
    iReqOp[k*4 +: 4] = op;
  endtask

  initial begin
    iRst_n    = 1'b0;
    iReqValid = '0;
    iReqX     = '0;
    iReqY     = '0;
    iReqOp    = '0;
    iRspReady = '0;
    tick();
    tick();

    // Reset state, including a valid request presented while reset is held
    iReqValid = 2'b01;
    #1;
    check("rst_ready",  64'(oReqReady), 64'h0);
    check("rst_rspval", 64'(oRspValid), 64'h0);
    check("rst_f",      64'(oRspF), 64'h0);
    check("rst_flag",   64'(oRspFlag), 64'h0);
    check("rst_rrptr",  64'(dut.rr_ptr_q), 64'h0);
    check("rst_owner",  64'(dut.owner_q), 64'h0);

    // Single ADD 5+7
    set_req(0, 32'd5, 32'd7, defs::OP_ADD);
    iReqValid = 2'b01;
    iRspReady = 2'b01;
    iRst_n    = 1'b1;
    #1;
    check("add_ready_c0", 64'(oReqReady), 64'h1);
    tick();
    iReqValid = 2'b00;
    check("add_ready_c1",  64'(oReqReady), 64'h0);
    check("add_rspval_c1", 64'(oRspValid), 64'h0);
    tick();
    check("add_rspval_c2", 64'(oRspValid), 64'h1);
    check("add_f",         64'(oRspF), 64'd12);
    check("add_flag",      64'(oRspFlag), 64'h0);
    tick();
    check("add_rspval_c3", 64'(oRspValid), 64'h0);
    check("add_rrptr",     64'(dut.rr_ptr_q), 64'h1);

    // Simultaneous requests after reset: req0 SUB 3-3, req1 AND
    iRst_n = 1'b0;
    tick();
    iRst_n = 1'b1;
    set_req(0, 32'd3, 32'd3, defs::OP_SUB);
    set_req(1, 32'h0000F0F0, 32'h00000FF0, defs::OP_AND);
    iReqValid = 2'b11;
    iRspReady = 2'b11;
    #1;
    check("sim_ready0", 64'(oReqReady), 64'h1);
    tick();
    iReqValid = 2'b10;
    check("sim_ready_exec", 64'(oReqReady), 64'h0);
    tick();
    check("sim_rspval0", 64'(oRspValid), 64'h1);
    check("sim_f0",      64'(oRspF), 64'h0);
    check("sim_flag0",   64'(oRspFlag), 64'b0100);
    tick();
    check("sim_ready1", 64'(oReqReady), 64'h2);
    tick();
    iReqValid = 2'b00;
    tick();
    check("sim_rspval1", 64'(oRspValid), 64'h2);
    check("sim_f1",      64'(oRspF), 64'h000000F0);
    check("sim_flag1",   64'(oRspFlag), 64'h0);
    tick();

    // Fairness: both requesters hold valid for four operations
    set_req(0, 32'd1, 32'd1, defs::OP_ADD);
    set_req(1, 32'd2, 32'd2, defs::OP_ADD);
    iReqValid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("fair_grant%0d", k), 64'(oReqReady), 64'(exp_g));
      check($sformatf("fair_onehot%0d", k), 64'($countones(oReqReady) <= 1), 64'h1);
      tick();
      check($sformatf("fair_exec_ready%0d", k), 64'(oReqReady), 64'h0);
      tick();
      check($sformatf("fair_rspval%0d", k), 64'(oRspValid), 64'(exp_g));
      check($sformatf("fair_f%0d", k), 64'(oRspF), (k % 2 == 0) ? 64'd2 : 64'd4);
      tick();
    end

    // Backpressure on req0 with req1 waiting; req1's ready bit is ignored
    set_req(0, 32'd10, 32'd20, defs::OP_ADD);
    set_req(1, 32'hFF00FF00, 32'h0F0F0F0F, defs::OP_XOR);
    iReqValid = 2'b11;
    iRspReady = 2'b00;
    #1;
    check("bp_grant0", 64'(oReqReady), 64'h1);
    tick();
    iReqValid = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) iRspReady = 2'b10;
      #1;
      check($sformatf("bp_rspval%0d", i), 64'(oRspValid), 64'h1);
      check($sformatf("bp_f%0d", i),      64'(oRspF), 64'd30);
      check($sformatf("bp_ready%0d", i),  64'(oReqReady), 64'h0);
      tick();
    end
    iRspReady = 2'b01;
    tick();
    check("bp_grant1", 64'(oReqReady), 64'h2);
    tick();
    iReqValid = 2'b00;
    iRspReady = 2'b11;
    tick();
    check("bp_rspval1", 64'(oRspValid), 64'h2);
    check("bp_f1",      64'(oRspF), 64'hF00FF00F);
    tick();

    // Signed overflow
    set_req(0, 32'h7FFFFFFF, 32'h00000001, defs::OP_ADD);
    iReqValid = 2'b01;
    tick();
    iReqValid = 2'b00;
    tick();
    check("ovf_rspval", 64'(oRspValid), 64'h1);
    check("ovf_f",      64'(oRspF), 64'h80000000);
    check("ovf_flag",   64'(oRspFlag), 64'b1010);
    tick();

    // Same operation again, reset while in EXEC
    iReqValid = 2'b01;
    tick();
    iReqValid = 2'b00;
    iRst_n    = 1'b0;
    tick();
    check("rstx_rspval", 64'(oRspValid), 64'h0);
    check("rstx_ready",  64'(oReqReady), 64'h0);
    check("rstx_f",      64'(oRspF), 64'h0);
    check("rstx_flag",   64'(oRspFlag), 64'h0);
    check("rstx_rrptr",  64'(dut.rr_ptr_q), 64'h0);
    iRst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rstx_norsp%0d", i), 64'(oRspValid), 64'h0);
    end
    check("rstx_f_after", 64'(oRspF), 64'h0);

`ifdef ALU_ARB_STATS_EN
    // Operation counter: three completions, then saturation
    set_req(0, 32'd1, 32'd2, defs::OP_ADD);
    iRspReady = 2'b11;
    for (int i = 0; i < 3; i++) begin
      iReqValid = 2'b01;
      tick();
      iReqValid = 2'b00;
      tick();
      tick();
    end
    check("cnt_three", 64'(oOpCnt), 64'd3);
    dut.op_cnt_q = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      iReqValid = 2'b01;
      tick();
      iReqValid = 2'b00;
      tick();
      tick();
    end
    check("cnt_sat", 64'(oOpCnt), 64'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational ALU instance between NREQ independent requesters using round-robin arbitration and valid/ready handshakes.
- Each accepted operation has its operands latched, is evaluated by the internal ALU, and returns a registered result plus flags to the requester that issued it.
- Sits between issue logic (e.g. multiple execution or microcode sources) and the single ALU datapath.
- Only one operation is in flight at a time.

Parameters:
- N, 32, operand and result width passed to the internal ALU.
- NREQ, 2, number of requesters; legal range 2..4.

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iRst_n  input  1  synchronous, active-low reset.
- iReqValid  input  NREQ  per-requester request valid.
- oReqReady  output  NREQ  per-requester accept; one-hot or zero.
- iReqX  input  NREQ*N  packed X operands; requester k occupies bits [k*N +: N].
- iReqY  input  NREQ*N  packed Y operands, same packing as iReqX.
- iReqOp  input  NREQ*4  packed ALU opcodes (defs ADD/SUB/AND/OR/XOR); requester k at [k*4 +: 4].
- oRspValid  output  NREQ  per-requester response valid; one-hot or zero.
- iRspReady  input  NREQ  per-requester response accept.
- oRspF  output  N  registered ALU result.
- oRspFlag  output  defs::t_flag  registered sign/zero/overflow/carryOut.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: oReqReady=0, oRspValid=0, oRspF=0, oRspFlag all 0, round-robin pointer rr_ptr=0, owner=0.
- IDLE, arbitration:
  - winner = first k with iReqValid[k]=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - oReqReady[winner]=1 combinationally; all other ready bits are 0.
  - No valid requests: oReqReady=0 and the FSM stays in IDLE.
- IDLE, handshake (iReqValid[winner] & oReqReady[winner]):
  - Latch X, Y and op from the winner's slice.
  - owner <= winner.
  - Next state EXEC.
- EXEC:
  - Internal ALU evaluates the latched operands.
  - oRspF and oRspFlag are registered from the ALU outputs.
  - Next state RESP.
  - oReqReady=0.
- RESP:
  - oRspValid[owner]=1; oRspF and oRspFlag hold stable.
  - oReqReady=0.
  - On iRspReady[owner]=1: oRspValid<=0, rr_ptr <= (owner+1) mod NREQ, next state IDLE.
  - iRspReady bits of non-owners are ignored.
- Latency: handshake at cycle t gives oRspValid at t+2. Minimum issue interval is 3 cycles.
- Requesters must hold iReqValid and payload stable until accepted. Dropping valid before acceptance is legal and withdraws the request.
- Unknown opcodes are passed through unchanged; the ALU's default decode applies (ADD).
- Arithmetic and flag semantics are exactly those of the internal ALU instance; no extra width handling in the arbiter.
- Backpressure: RESP holds indefinitely while iRspReady[owner]=0. No new grants during EXEC or RESP.
- Simultaneous requests in IDLE: only the winner is accepted. Losers keep valid asserted and are served in later IDLE cycles.
- rr_ptr wrap-around: owner=NREQ-1 sets rr_ptr to 0.
- Reset asserted in any state: next edge returns to IDLE with all reset values. An in-flight operation is discarded and no response is issued.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds output oOpCnt, 16 bits.
  - Increments on every RESP handshake (oRspValid[owner] & iRspReady[owner]).
  - Saturates at 16'hFFFF; reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan (N=32, NREQ=2):
- Single ADD: req0 ADD X=5, Y=7, accepted cycle 0, iRspReady[0]=1 → oRspValid[0]=1 at cycle 2, oRspF=12, zero=0, carryOut=0, overflow=0; FSM back in IDLE at cycle 3.
- Simultaneous requests after reset: req0 SUB 3-3 and req1 AND 0x0000F0F0 & 0x00000FF0.
  - req0 is served first: oRspF=0, zero=1, carryOut=0.
  - req1 is served next: oRspF=0x000000F0, oRspValid[1] only.
- Fairness: both requesters hold valid for 4 operations → grant order 0,1,0,1; oReqReady never has two bits set.
- Backpressure: iRspReady[0]=0 for 5 cycles with req1 valid → oRspValid[0] and oRspF stable, oReqReady=0. After iRspReady[0]=1, req1 is granted in the following IDLE cycle.
- Overflow, plus reset mid-operation:
  - ADD 0x7FFFFFFF+1 → oRspF=0x80000000, sign=1, overflow=1.
  - Repeat it with iRst_n=0 during EXEC → next cycle all outputs are 0, no response is issued, rr_ptr=0.
- ALU_ARB_STATS_EN:
  - 3 completed operations → oOpCnt=3.
  - Counter preloaded near 0xFFFF and 2 more operations → stays at 0xFFFF.
